// File: rtl/ase_emul_ooo_rsp_sorter.sv
// ase_emul_ooo_rsp_sorter
// Reorder buffer for the source side of an emulated out-of-order Avalon
// response channel. Tags are issued in order from the tail pointer, tagged
// responses land in any order into a payload RAM, and the head slot is
// drained strictly in allocation order.
//
// Handshakes:
//   alloc: a request is taken on a cycle with alloc_req && alloc_ready; it
//          consumes alloc_tag. alloc_req while !alloc_ready is ignored.
//   rsp:   rsp_valid has no back-pressure; every valid beat is either
//          captured (legal) or dropped and flagged in err_bad_rsp.
//   out:   out_valid/out_* depend only on registered state; a beat
//          transfers on out_valid && out_ready. While out_valid && !out_ready
//          the out_* fields hold steady.
module ase_emul_ooo_rsp_sorter #(
  parameter int DATA_WIDTH     = 512,
  parameter int RESPONSE_WIDTH = 2,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_req,
  output logic                      alloc_ready,
  output logic [TAG_WIDTH-1:0]      alloc_tag,
  input  logic                      rsp_valid,
  input  logic [TAG_WIDTH-1:0]      rsp_tag,
  input  logic [DATA_WIDTH-1:0]     rsp_data,
  input  logic [RESPONSE_WIDTH-1:0] rsp_response,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [RESPONSE_WIDTH-1:0] out_response,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [TAG_WIDTH:0]        count,
  output logic                      err_bad_rsp
);

  localparam int DEPTH = 2 ** TAG_WIDTH;
  localparam int PW    = TAG_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + RESPONSE_WIDTH;

  // Pointers carry one extra bit so full (count==DEPTH) and empty differ.
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [DEPTH-1:0]     filled_q, filled_d;
  logic                 err_q, err_d;
  logic [EW-1:0]        ram_q [DEPTH];

  logic [TAG_WIDTH-1:0] head_idx;
  logic [TAG_WIDTH-1:0] rsp_off;
  logic                 do_alloc;
  logic                 do_pop;
  logic                 rsp_legal;
  logic [EW-1:0]        head_entry;

  assign head_idx    = head_q[TAG_WIDTH-1:0];
  assign count       = tail_q - head_q;
  assign alloc_ready = (count != PW'(DEPTH));
  assign alloc_tag   = tail_q[TAG_WIDTH-1:0];
  assign out_tag     = head_idx;
  assign out_valid   = filled_q[head_idx];
  assign err_bad_rsp = err_q;

  // Distance of the returned tag from the head; it is outstanding only if
  // that distance falls inside the pre-alloc window [0, count).
  assign rsp_off   = rsp_tag - head_idx;
  assign rsp_legal = rsp_valid && ({1'b0, rsp_off} < count) && !filled_q[rsp_tag];

  assign do_alloc  = alloc_req && alloc_ready;
  assign do_pop    = out_valid && out_ready;

  assign head_entry   = ram_q[head_idx];
  assign out_data     = head_entry[EW-1:RESPONSE_WIDTH];
  assign out_response = head_entry[RESPONSE_WIDTH-1:0];

  // Next-state for pointers, fill bits and the sticky error flag.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    filled_d = filled_q;
    err_d    = err_q;
    if (do_alloc) tail_d = tail_q + PW'(1);
    if (do_pop) begin
      filled_d[head_idx] = 1'b0;
      head_d             = head_q + PW'(1);
    end
    // A legal response never targets a filled head, so it cannot collide
    // with the pop clear above.
    if (rsp_legal) filled_d[rsp_tag] = 1'b1;
    if (rsp_valid && !rsp_legal) err_d = 1'b1;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      filled_q <= filled_d;
      err_q    <= err_d;
    end
  end

  // Payload RAM; contents are only meaningful where the fill bit is set.
  always_ff @(posedge clk) begin
    if (rsp_legal) ram_q[rsp_tag] <= {rsp_data, rsp_response};
  end

endmodule

// File: tb/tb_ase_emul_ooo_rsp_sorter.sv
// Directed bench for ase_emul_ooo_rsp_sorter (16-bit payload, 16 slots).
module tb_ase_emul_ooo_rsp_sorter;

  localparam int DW = 16;
  localparam int RW = 2;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_req;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_data;
  logic [RW-1:0] rsp_response;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_response;
  logic [TW-1:0] out_tag;
  logic [TW:0]   count;
  logic          err_bad_rsp;

  int errors = 0;
  int checks = 0;

  ase_emul_ooo_rsp_sorter #(
    .DATA_WIDTH(DW), .RESPONSE_WIDTH(RW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_response(rsp_response),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_response(out_response), .out_tag(out_tag),
    .count(count), .err_bad_rsp(err_bad_rsp)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_tag      = '0;
    rsp_data     = '0;
    rsp_response = '0;
    out_ready    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Driver tasks
  task automatic drv_alloc();
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
  endtask

  task automatic drv_rsp(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                         input logic [RW-1:0] resp);
    rsp_valid    = 1'b1;
    rsp_tag      = tag;
    rsp_data     = data;
    rsp_response = resp;
    step();
    rsp_valid    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_alloc_ready got=%b exp=1", alloc_ready); end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL rst_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL rst_out_tag got=%0d exp=0", out_tag); end
    checks++; if (err_bad_rsp !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_bad_rsp); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_in_order();
    logic [DW-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (alloc_tag !== TW'(i)) begin errors++; $display("FAIL io_alloc_tag got=%0d exp=%0d", alloc_tag, i); end
      drv_alloc();
    end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL io_count3 got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) drv_rsp(TW'(i), DW'(16'hA0 + i), RW'(i + 1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_d = DW'(16'hA0 + i);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_response !== RW'(i + 1))
        begin errors++; $display("FAIL io_out%0d got v=%b d=%h r=%0d exp v=1 d=%h r=%0d", i, out_valid, out_data, out_response, exp_d, i + 1); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL io_drained got count=%0d v=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_reverse();
    logic [DW-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) drv_alloc();
    for (int t = 3; t >= 1; t--) begin
      drv_rsp(TW'(t), DW'(16'h50 + t), 2'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rev_early_valid tag=%0d got=%b exp=0", t, out_valid); end
    end
    rsp_valid = 1'b1; rsp_tag = 4'd0; rsp_data = 16'h50; rsp_response = 2'd0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rev_same_cycle_valid got=%b exp=0", out_valid); end
    step();
    rsp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rev_valid_rise got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = DW'(16'h50 + i);
      checks++; if (out_valid !== 1'b1 || out_tag !== TW'(i) || out_data !== exp_d)
        begin errors++; $display("FAIL rev_drain%0d got v=%b tag=%0d d=%h exp v=1 tag=%0d d=%h", i, out_valid, out_tag, out_data, i, exp_d); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 5'd0 || err_bad_rsp !== 1'b0) begin errors++; $display("FAIL rev_end got count=%0d err=%b exp 0/0", count, err_bad_rsp); end
  endtask

  task automatic test_full_wrap();
    logic [DW-1:0] exp_q[$];
    logic [TW-1:0] exp_tag_q[$];
    int            pend_tag[$];
    logic [DW-1:0] pend_data[$];
    int            n_alloc, n_pop, cyc, idx;
    logic          do_a, do_p;
    logic [DW-1:0] exp_d;
    logic [TW-1:0] exp_t;

    apply_reset();
    for (int i = 0; i < 16; i++) drv_alloc();
    checks++; if (alloc_ready !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL full got ready=%b count=%0d exp 0/16", alloc_ready, count); end
    drv_alloc();
    checks++; if (count !== 5'd16 || alloc_tag !== 4'd0) begin errors++; $display("FAIL full_ignore got count=%0d tag=%0d exp 16/0", count, alloc_tag); end
    drv_rsp(4'd0, 16'h7700, 2'd0);
    out_ready = 1'b1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", alloc_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0 || count !== 5'd15)
      begin errors++; $display("FAIL full_pop got ready=%b tag=%0d count=%0d exp 1/0/15", alloc_ready, alloc_tag, count); end

    // 40 transactions with random response order and random back-pressure.
    apply_reset();
    n_alloc = 0; n_pop = 0; cyc = 0;
    while (n_pop < 40 && cyc < 3000) begin
      do_a = (n_alloc < 40) && alloc_ready && ($urandom_range(0, 3) != 0);
      alloc_req = do_a;
      rsp_valid = 1'b0;
      if (pend_tag.size() > 0 && $urandom_range(0, 2) != 0) begin
        idx          = $urandom_range(0, pend_tag.size() - 1);
        rsp_valid    = 1'b1;
        rsp_tag      = TW'(pend_tag[idx]);
        rsp_data     = pend_data[idx];
        rsp_response = rsp_data[1:0];
        pend_tag.delete(idx);
        pend_data.delete(idx);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      do_p = out_valid && out_ready;
      if (do_p) begin
        exp_d = exp_q.pop_front();
        exp_t = exp_tag_q.pop_front();
        checks++; if (out_data !== exp_d || out_tag !== exp_t || out_response !== exp_d[1:0])
          begin errors++; $display("FAIL wrap_out%0d got tag=%0d d=%h exp tag=%0d d=%h", n_pop, out_tag, out_data, exp_t, exp_d); end
        n_pop++;
      end
      if (do_a) begin
        exp_d = DW'(16'h1000 + n_alloc * 37);
        exp_q.push_back(exp_d);
        exp_tag_q.push_back(alloc_tag);
        pend_tag.push_back(int'(alloc_tag));
        pend_data.push_back(exp_d);
        n_alloc++;
      end
      step();
      cyc++;
    end
    idle_inputs();
    checks++; if (n_pop != 40) begin errors++; $display("FAIL wrap_timeout got pops=%0d exp=40", n_pop); end
    checks++; if (err_bad_rsp !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL wrap_end got err=%b count=%0d exp 0/0", err_bad_rsp, count); end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    drv_alloc();
    drv_alloc();
    drv_rsp(4'd0, 16'hB0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin rsp_valid = 1'b1; rsp_tag = 4'd1; rsp_data = 16'hB1; rsp_response = 2'd3; end
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hB0 || out_response !== 2'd2)
        begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=00b0", i, out_valid, out_data); end
      step();
      rsp_valid = 1'b0;
    end
    checks++; if (err_bad_rsp !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL bp_state got err=%b count=%0d exp 0/2", err_bad_rsp, count); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_data !== 16'hB1 || out_response !== 2'd3)
      begin errors++; $display("FAIL bp_second got v=%b tag=%0d d=%h exp v=1 tag=1 d=00b1", out_valid, out_tag, out_data); end
    step();
    out_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL bp_drained got count=%0d exp=0", count); end
  endtask

  task automatic test_errors();
    apply_reset();
    drv_alloc();
    drv_alloc();
    drv_rsp(4'd7, 16'hEE, 2'd0);
    checks++; if (err_bad_rsp !== 1'b1 || out_valid !== 1'b0 || count !== 5'd2)
      begin errors++; $display("FAIL err_not_outstanding got err=%b v=%b count=%0d exp 1/0/2", err_bad_rsp, out_valid, count); end
    drv_rsp(4'd0, 16'hC0, 2'd1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hC0) begin errors++; $display("FAIL err_head got v=%b d=%h exp 1/00c0", out_valid, out_data); end
    drv_rsp(4'd0, 16'hDD, 2'd3);
    checks++; if (err_bad_rsp !== 1'b1 || out_data !== 16'hC0 || out_response !== 2'd1)
      begin errors++; $display("FAIL err_dup got err=%b d=%h r=%0d exp 1/00c0/1", err_bad_rsp, out_data, out_response); end
    // Same-cycle alloc+response to the tag being allocated is illegal.
    apply_reset();
    alloc_req = 1'b1;
    drv_rsp(4'd0, 16'h11, 2'd0);
    alloc_req = 1'b0;
    checks++; if (err_bad_rsp !== 1'b1 || out_valid !== 1'b0 || count !== 5'd1)
      begin errors++; $display("FAIL err_same_cycle got err=%b v=%b count=%0d exp 1/0/1", err_bad_rsp, out_valid, count); end
  endtask

  task automatic test_reset_mid_flight();
    apply_reset();
    for (int i = 0; i < 5; i++) drv_alloc();
    drv_rsp(4'd1, 16'h21, 2'd0);
    drv_rsp(4'd2, 16'h22, 2'd0);
    reset = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0 || alloc_tag !== 4'd0)
      begin errors++; $display("FAIL mid_reset got count=%0d v=%b tag=%0d exp 0/0/0", count, out_valid, alloc_tag); end
    step();
    reset = 1'b0;
    step();
    drv_rsp(4'd3, 16'h23, 2'd0);
    checks++; if (err_bad_rsp !== 1'b1 || out_valid !== 1'b0 || count !== 5'd0)
      begin errors++; $display("FAIL mid_late_rsp got err=%b v=%b count=%0d exp 1/0/0", err_bad_rsp, out_valid, count); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reverse();
    test_full_wrap();
    test_back_pressure();
    test_errors();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
